// File: rtl/pulse_gate_ctrl.sv
// Gated pulse-frequency measurement controller.
// The raw pulse input is synchronized into clk, and its rising edges are
// counted over a fixed window of GATE_CYCLES clocks. The result is then
// published on countOut together with a one-cycle countValid strobe.
// The controller runs one-shot on start, or back-to-back while contMode is high.
//
// state | meaning
// IDLE  | waiting for start or contMode
// ARM   | clear gate timer, edge counter and saturation flag
// GATE  | window open, count synchronized rising edges
// DONE  | latch result, strobe countValid, rearm or go idle
module pulse_gate_ctrl #(
  parameter int GATE_CYCLES = 100000000,
  parameter int GATE_W      = 27,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             contMode,
  input  logic             pulseIn,
  output logic             busy,
  output logic [CNT_W-1:0] countOut,
  output logic             countValid,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state;
  state_t            state_nxt;
  logic              s1;
  logic              s2;
  logic              s3;
  logic              pulse_edge;
  logic [GATE_W-1:0] gate_timer;
  logic [CNT_W-1:0]  edge_cnt;
  logic              ovf;

  assign pulse_edge = s2 & ~s3;

  // Three-flop synchronizer; the third flop provides the previous level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pulseIn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start || contMode) state_nxt = ARM;
      ARM:     state_nxt = GATE;
      GATE:    if (gate_timer == GATE_LAST) state_nxt = DONE;
      DONE:    state_nxt = contMode ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gate timer and saturating edge counter.
  // Edges seen outside the gate window are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_timer <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        ARM: begin
          gate_timer <= '0;
          edge_cnt   <= '0;
          ovf        <= 1'b0;
        end
        GATE: begin
          gate_timer <= gate_timer + GATE_W'(1);
          if (pulse_edge) begin
            if (edge_cnt == CNT_MAX) ovf <= 1'b1;
            else                     edge_cnt <= edge_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs. The result is latched while in DONE; busy tracks the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      countOut   <= '0;
      overflow   <= 1'b0;
      countValid <= 1'b0;
    end else begin
      busy       <= (state_nxt != IDLE);
      countValid <= (state == DONE);
      if (state == DONE) begin
        countOut <= edge_cnt;
        overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_pulse_gate_ctrl.sv
// Scoreboard bench for pulse_gate_ctrl.
// Two instances share the same stimulus: a 4-bit counter and a 3-bit counter
// that saturates. A reference model counts rising input samples over each
// window and queues the expected result for each instance. Separate monitors
// pop these results and compare them whenever countValid fires.
module tb_pulse_gate_ctrl;

  localparam int GC    = 20;
  localparam int NHIST = 8192;

  typedef struct {
    int cyc;
    int cnt;
    int ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       contMode;
  logic       pulseIn;
  logic       busy4, busy3;
  logic [3:0] count4;
  logic [2:0] count3;
  logic       valid4, valid3;
  logic       ovf4, ovf3;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pmode  = 0;
  int   vld4   = 0;
  int   last4_cnt, last4_ovf, last3_cnt, last3_ovf;
  bit   p_hist [NHIST];
  exp_t q4[$];
  exp_t q3[$];

  pulse_gate_ctrl #(.GATE_CYCLES(GC), .GATE_W(5), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .contMode(contMode), .pulseIn(pulseIn),
    .busy(busy4), .countOut(count4), .countValid(valid4), .overflow(ovf4));

  pulse_gate_ctrl #(.GATE_CYCLES(GC), .GATE_W(5), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .contMode(contMode), .pulseIn(pulseIn),
    .busy(busy3), .countOut(count3), .countValid(valid3), .overflow(ovf3));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start(output int k);
    k = cyc + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference model: windows start at the edge where a request is accepted.
  // Each window covers GC input samples, and its result appears GC+2 cycles later.
  initial begin
    bit idle;
    int win_k;
    int n;
    idle  = 1'b1;
    win_k = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        p_hist[cyc % NHIST] = 1'b0;
        idle = 1'b1;
      end else begin
        p_hist[cyc % NHIST] = pulseIn;
        if (idle) begin
          if (start || contMode) begin
            idle  = 1'b0;
            win_k = cyc;
          end
        end else if (cyc == win_k + GC + 2) begin
          n = 0;
          for (int m = win_k; m < win_k + GC; m++)
            if (p_hist[m % NHIST] && !p_hist[(m - 1) % NHIST]) n++;
          q4.push_back('{cyc: cyc, cnt: (n > 15) ? 15 : n, ovf: (n > 15) ? 1 : 0});
          q3.push_back('{cyc: cyc, cnt: (n > 7) ? 7 : n, ovf: (n > 7) ? 1 : 0});
          if (contMode) win_k = cyc;
          else          idle  = 1'b1;
        end
      end
    end
  end

  // Monitor for the 4-bit instance.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (q4.size() > 0 && q4[0].cyc < cyc) begin
        chk("strobe4_missing_at", cyc, q4[0].cyc);
        void'(q4.pop_front());
      end
      if (valid4) begin
        vld4++;
        if (prev) chk("valid4_consecutive", 1, 0);
        if (q4.size() == 0) chk("valid4_unexpected", 1, 0);
        else begin
          e = q4.pop_front();
          chk("valid4_cycle", cyc, e.cyc);
          chk("count4", int'(count4), e.cnt);
          chk("ovf4", int'(ovf4), e.ovf);
          last4_cnt = int'(count4);
          last4_ovf = int'(ovf4);
        end
      end
      prev = valid4;
    end
  end

  // Monitor for the 3-bit instance.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (q3.size() > 0 && q3[0].cyc < cyc) begin
        chk("strobe3_missing_at", cyc, q3[0].cyc);
        void'(q3.pop_front());
      end
      if (valid3) begin
        if (prev) chk("valid3_consecutive", 1, 0);
        if (q3.size() == 0) chk("valid3_unexpected", 1, 0);
        else begin
          e = q3.pop_front();
          chk("valid3_cycle", cyc, e.cyc);
          chk("count3", int'(count3), e.cnt);
          chk("ovf3", int'(ovf3), e.ovf);
          last3_cnt = int'(count3);
          last3_ovf = int'(ovf3);
        end
      end
      prev = valid3;
    end
  end

  // Pulse generator: 0 = held low, 2/4 = square-wave period, 1 = random level each cycle.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph++;
      case (pmode)
        2:       pulseIn = ph[0];
        4:       pulseIn = ph[1];
        1:       pulseIn = 1'($urandom_range(0, 1));
        default: pulseIn = 1'b0;
      endcase
    end
  end

  initial begin
    int k;
    int v0;
    reset    = 1'b1;
    start    = 1'b0;
    contMode = 1'b0;
    pulseIn  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle with no stimulus.
    repeat (50) begin
      @(negedge clk);
      chk("idle_busy", int'(busy4), 0);
      chk("idle_count", int'(count4), 0);
      chk("idle_ovf", int'(ovf4), 0);
      chk("idle_valid", int'(valid4), 0);
    end

    // One-shot measurement with a period-4 input.
    pmode = 4;
    repeat (8) @(negedge clk);
    pulse_start(k);
    wait_until(k + 5);
    chk("busy_in_gate", int'(busy4), 1);
    wait_until(k + 23);
    chk("busy_after_result", int'(busy4), 0);
    chk("p4_count", last4_cnt, 5);
    chk("p4_ovf", last4_ovf, 0);
    wait_until(k + 30);

    // Input held low, with start re-pulsed mid-window. The re-pulse must be ignored.
    pmode = 0;
    repeat (4) @(negedge clk);
    v0 = vld4;
    pulse_start(k);
    wait_until(k + 9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(k + 50);
    chk("restart_ignored_strobes", vld4 - v0, 1);
    chk("zero_count", last4_cnt, 0);

    // Period-2 input: 10 edges. The 3-bit instance saturates; the next period-4 window recovers.
    pmode = 2;
    repeat (4) @(negedge clk);
    pulse_start(k);
    wait_until(k + 25);
    chk("p2_count4", last4_cnt, 10);
    chk("p2_count3", last3_cnt, 7);
    chk("p2_ovf3", last3_ovf, 1);
    pmode = 4;
    repeat (4) @(negedge clk);
    pulse_start(k);
    wait_until(k + 25);
    chk("p4_count3", last3_cnt, 5);
    chk("p4_ovf3", last3_ovf, 0);

    // Reset mid-window: outputs clear at once and the partial count is discarded.
    v0 = vld4;
    pulse_start(k);
    wait_until(k + 11);
    reset = 1'b1;
    #1;
    chk("rst_busy", int'(busy4), 0);
    chk("rst_busy3", int'(busy3), 0);
    chk("rst_count", int'(count4), 0);
    chk("rst_count3", int'(count3), 0);
    chk("rst_valid", int'(valid4), 0);
    chk("rst_ovf", int'(ovf4), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_until(k + 40);
    chk("rst_no_strobe", vld4 - v0, 0);
    pulse_start(k);
    wait_until(k + 25);
    chk("after_rst_strobes", vld4 - v0, 1);
    chk("after_rst_count", last4_cnt, 5);

    // Continuous mode; contMode is dropped mid-window at k+50.
    v0 = vld4;
    k = cyc + 1;
    contMode = 1'b1;
    wait_until(k + 50);
    contMode = 1'b0;
    wait_until(k + 100);
    chk("cont_strobes", vld4 - v0, 3);
    chk("cont_busy_end", int'(busy4), 0);

    // Random pulse levels with random start and contMode activity.
    pmode = 1;
    repeat (30) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else if (r == 4) begin
        contMode = ~contMode;
      end
      repeat ($urandom_range(1, 15)) @(negedge clk);
    end
    contMode = 1'b0;
    repeat (70) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
